mean_sched: RTL and testbench
=============================

Name: mean_sched

Overview:
- Time-multiplexed scheduler that shares one 4-tap moving-average engine between NCH independent sample streams.
- Keeps a private tap history per channel and grants one request at a time in round-robin order.
- Shifts the accepted sample into that channel's history, computes the truncated mean, and presents it with its channel id on a valid/ready output.
- Sits between per-channel sample producers and a single downstream consumer of averaged results.

Parameters:
- NCH, 4, number of requesting channels (2..8)
- DW, 4, sample and mean width in bits
- TAPS, 4, averaging window length; must be a power of two
- LOG2_TAPS, 2, log2(TAPS); sets the sum growth and the shift amount

Ports:
- clk  input  1  single clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- req_valid  input  NCH  per-channel sample valid
- req_data  input  NCH*DW  per-channel sample; channel i occupies bits [i*DW +: DW]
- req_ready  output  NCH  one-hot grant/accept strobe
- clr  input  NCH  per-channel history clear
- out_valid  output  1  result valid
- out_ready  input  1  downstream accept
- out_ch  output  clog2(NCH)  channel id of the result
- out_mean  output  DW  averaged value
- out_warm  output  1  channel has received at least TAPS samples since its last clear or reset

Behaviour:
- Reset (rst_n low, asynchronous), all of the following clear immediately:
  - state=IDLE, rr_ptr=0
  - all histories and sample counters = 0
  - out_valid=0, out_ch=0, out_mean=0, out_warm=0
  - req_ready=0
- FSM has three states: IDLE, CALC, OUT.
- IDLE:
  - g = first channel with req_valid=1, searching rr_ptr, rr_ptr+1, ... mod NCH.
  - req_ready[g]=1 combinationally in this cycle only; all other req_ready bits are 0.
  - No req_valid set: stay in IDLE, req_ready=0.
  - At the edge: hist[g][k] <= hist[g][k-1] for k=1..TAPS-1, hist[g][0] <= req_data[g].
  - At the same edge: cnt[g] increments, saturating at TAPS. gsel <= g. Next state CALC.
- CALC:
  - sum = sum of hist[gsel][0..TAPS-1], width DW+LOG2_TAPS, no overflow possible.
  - At the edge: out_mean <= sum >> LOG2_TAPS (truncation, no rounding), out_ch <= gsel, out_warm <= (cnt[gsel]==TAPS), out_valid <= 1.
  - Next state OUT.
- OUT:
  - out_valid=1; out_mean, out_ch and out_warm are held stable.
  - On out_ready=1: out_valid <= 0, rr_ptr <= (gsel+1) mod NCH, next state IDLE.
  - While waiting in OUT, req_ready stays 0.
- Latency and throughput:
  - Accept edge to out_valid high is 2 clocks.
  - Minimum 3 clocks per result when out_ready is held at 1.
- clr[i]:
  - Synchronous. Zeroes hist[i] and cnt[i] at the next edge, in any state.
  - Same cycle as an accept on channel i: clear wins for the old taps. hist[i][0] = new sample, the other taps = 0, cnt[i] = 1. The handshake still completes.
  - clr on gsel during CALC: the result uses the pre-clear history; the history is zeroed at that same edge.
  - clr on gsel during OUT: the held result is not altered.
- Fairness: the channel just served drops to lowest priority. Starvation is bounded to NCH-1 grants.
- req_valid dropping while not granted: no effect. Producers must hold data until req_ready.
- rst_n asserted mid-transaction: the in-flight result is discarded and no output is produced for it.

Test Plan:
- Channel 0 only, samples 4, 8, 12, 0 with out_ready=1 → out_mean 1, 3, 6, 6; out_warm 0, 0, 0, 1; out_ch=0; out_valid 2 clocks after each accept.
- All channels valid continuously, out_ready=1 → grant order 0, 1, 2, 3, 0, 1; one result every 3 clocks; req_ready one-hot.
- Result pending, out_ready=0 for 5 cycles → out_valid/out_mean/out_ch stable, req_ready=0 throughout; release → IDLE and next grant to gsel+1.
- Channel 1 fed 15, 15, 15, 15 → out_mean 3, 7, 11, 15; sum 60 with no overflow; out_warm=1 on the last result.
- Channel 2 history all 15; assert clr[2] together with the accept of sample 8 → out_mean 2, out_warm 0; the next sample 8 gives out_mean 4.
- rst_n low for 1 cycle while in OUT → out_valid, out_mean and out_ch go to 0 asynchronously; with channels 0 and 3 both valid afterwards, the first grant goes to channel 0 with zeroed history.

Source files
------------

// File: rtl/mean_sched_if.sv
// Request/result bundle for mean_sched.
// Per-channel producers drive req_valid/req_data/clr and see the one-hot req_ready grant.
// A single consumer sees out_valid/out_ch/out_mean/out_warm and drives out_ready.
// master: producer/consumer side. slave: the scheduler.
interface mean_sched_if #(
  parameter int unsigned NCH = 4,
  parameter int unsigned DW  = 4
) ();
  localparam int unsigned CHW = (NCH > 1) ? $clog2(NCH) : 1;

  logic [NCH-1:0]    req_valid;
  logic [NCH*DW-1:0] req_data;
  logic [NCH-1:0]    req_ready;
  logic [NCH-1:0]    clr;
  logic              out_valid;
  logic              out_ready;
  logic [CHW-1:0]    out_ch;
  logic [DW-1:0]     out_mean;
  logic              out_warm;

  modport master (
    output req_valid, req_data, clr, out_ready,
    input  req_ready, out_valid, out_ch, out_mean, out_warm
  );

  modport slave (
    input  req_valid, req_data, clr, out_ready,
    output req_ready, out_valid, out_ch, out_mean, out_warm
  );
endinterface

// File: rtl/mean_sched.sv
// Round-robin scheduler sharing one TAPS-point moving-average engine among NCH streams.
// Each channel keeps its own tap history and fill counter; one request is accepted at a
// time, averaged (truncated) and presented with its channel id on a valid/ready output.
// Ports: clk, rst_n (async active-low), bus (mean_sched_if.slave):
//   req_valid/req_data/req_ready per channel, clr per channel,
//   out_valid/out_ready/out_ch/out_mean/out_warm result handshake.
module mean_sched #(
  parameter int unsigned NCH       = 4,
  parameter int unsigned DW        = 4,
  parameter int unsigned TAPS      = 4,
  parameter int unsigned LOG2_TAPS = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  mean_sched_if.slave  bus
);
  localparam int unsigned CHW = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int unsigned CW  = LOG2_TAPS + 1;
  localparam int unsigned SW  = DW + LOG2_TAPS;

  typedef enum logic [1:0] {IDLE, CALC, OUT} state_t;

  state_t          state_q, state_d;
  logic [CHW-1:0]  rr_ptr_q, rr_ptr_d;
  logic [CHW-1:0]  gsel_q, gsel_d;
  logic [DW-1:0]   hist_q [NCH][TAPS];
  logic [DW-1:0]   hist_d [NCH][TAPS];
  logic [CW-1:0]   cnt_q [NCH];
  logic [CW-1:0]   cnt_d [NCH];
  logic            out_valid_q, out_valid_d;
  logic [CHW-1:0]  out_ch_q, out_ch_d;
  logic [DW-1:0]   out_mean_q, out_mean_d;
  logic            out_warm_q, out_warm_d;

  logic [NCH-1:0]  req_ready_c;
  logic            gnt_found_c;
  logic [CHW-1:0]  gnt_idx_c;
  logic [SW-1:0]   sum_c;

  // Round-robin search starting at rr_ptr
  always_comb begin
    logic [CHW-1:0] cand;
    gnt_found_c = 1'b0;
    gnt_idx_c   = '0;
    cand        = '0;
    for (int unsigned j = 0; j < NCH; j++) begin
      cand = CHW'((32'(rr_ptr_q) + j) % NCH);
      if (!gnt_found_c && bus.req_valid[cand]) begin
        gnt_found_c = 1'b1;
        gnt_idx_c   = cand;
      end
    end
  end

  // Window sum for the selected channel; width cannot overflow
  always_comb begin
    sum_c = '0;
    for (int unsigned k = 0; k < TAPS; k++) begin
      sum_c = sum_c + SW'(hist_q[gsel_q][k]);
    end
  end

  // Next-state, datapath updates and grant
  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    gsel_d      = gsel_q;
    hist_d      = hist_q;
    cnt_d       = cnt_q;
    out_valid_d = out_valid_q;
    out_ch_d    = out_ch_q;
    out_mean_d  = out_mean_q;
    out_warm_d  = out_warm_q;
    req_ready_c = '0;

    unique case (state_q)
      IDLE: begin
        // rst_n gate keeps the grant low while reset is held
        if (gnt_found_c && rst_n) begin
          req_ready_c[gnt_idx_c] = 1'b1;
          for (int unsigned k = TAPS - 1; k > 0; k--) begin
            hist_d[gnt_idx_c][k] = hist_q[gnt_idx_c][k-1];
          end
          hist_d[gnt_idx_c][0] = bus.req_data[32'(gnt_idx_c)*DW +: DW];
          if (cnt_q[gnt_idx_c] != CW'(TAPS)) begin
            cnt_d[gnt_idx_c] = cnt_q[gnt_idx_c] + CW'(1);
          end
          gsel_d  = gnt_idx_c;
          state_d = CALC;
        end
      end
      CALC: begin
        out_mean_d  = DW'(sum_c >> LOG2_TAPS);
        out_ch_d    = gsel_q;
        out_warm_d  = (cnt_q[gsel_q] == CW'(TAPS));
        out_valid_d = 1'b1;
        state_d     = OUT;
      end
      OUT: begin
        if (bus.out_ready) begin
          out_valid_d = 1'b0;
          rr_ptr_d    = CHW'((32'(gsel_q) + 32'd1) % NCH);
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Clear overrides the old taps; a same-cycle accepted sample survives in tap 0
    for (int unsigned i = 0; i < NCH; i++) begin
      if (bus.clr[i]) begin
        for (int unsigned k = 0; k < TAPS; k++) begin
          hist_d[i][k] = '0;
        end
        cnt_d[i] = '0;
        if (req_ready_c[i]) begin
          hist_d[i][0] = bus.req_data[i*DW +: DW];
          cnt_d[i]     = CW'(1);
        end
      end
    end
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      rr_ptr_q    <= '0;
      gsel_q      <= '0;
      hist_q      <= '{default: '{default: '0}};
      cnt_q       <= '{default: '0};
      out_valid_q <= 1'b0;
      out_ch_q    <= '0;
      out_mean_q  <= '0;
      out_warm_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      gsel_q      <= gsel_d;
      hist_q      <= hist_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      out_ch_q    <= out_ch_d;
      out_mean_q  <= out_mean_d;
      out_warm_q  <= out_warm_d;
    end
  end

  assign bus.req_ready = req_ready_c;
  assign bus.out_valid = out_valid_q;
  assign bus.out_ch    = out_ch_q;
  assign bus.out_mean  = out_mean_q;
  assign bus.out_warm  = out_warm_q;

endmodule

// File: tb/tb_mean_sched.sv
// Directed bench for mean_sched (NCH=4, DW=4, TAPS=4).
module tb_mean_sched;
  logic clk;
  logic rst_n;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   exp_order [6] = '{0, 1, 2, 3, 0, 1};

  mean_sched_if #(.NCH(4), .DW(4)) bus ();

  mean_sched #(.NCH(4), .DW(4), .TAPS(4), .LOG2_TAPS(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One transaction on channel ch with out_ready=1; entered and left at posedge+1
  task automatic do_one(input int ch, input logic [3:0] data, input logic [3:0] clr_m,
                        input logic [3:0] exp_mean, input logic exp_warm);
    bit got;
    bus.req_valid[ch]          = 1'b1;
    bus.req_data[ch*4 +: 4]    = data;
    bus.clr                    = clr_m;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (bus.req_ready != 4'd0) got = 1'b1;
      else @(posedge clk);
    end
    check("grant_seen", 32'(got), 32'd1);
    check("grant_onehot", 32'(bus.req_ready), 32'd1 << ch);
    @(posedge clk); #1;
    bus.req_valid[ch] = 1'b0;
    bus.clr           = '0;
    @(negedge clk);
    check("lat_calc_valid", 32'(bus.out_valid), 32'd0);
    @(negedge clk);
    check("out_valid", 32'(bus.out_valid), 32'd1);
    check("out_ch", 32'(bus.out_ch), 32'(ch));
    check("out_mean", 32'(bus.out_mean), 32'(exp_mean));
    check("out_warm", 32'(bus.out_warm), 32'(exp_warm));
    @(posedge clk); #1;
  endtask

  initial begin
    int ng;
    int last;
    int idx;

    // Reset with a request pending: nothing may be granted
    rst_n         = 1'b0;
    bus.req_valid = 4'b0001;
    bus.req_data  = '0;
    bus.clr       = '0;
    bus.out_ready = 1'b1;
    @(posedge clk); @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_out_mean", 32'(bus.out_mean), 32'd0);
    check("rst_out_ch", 32'(bus.out_ch), 32'd0);
    check("rst_out_warm", 32'(bus.out_warm), 32'd0);
    check("rst_req_ready", 32'(bus.req_ready), 32'd0);
    bus.req_valid = '0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Channel 0 warm-up: 4, 8, 12, 0
    do_one(0, 4'd4,  4'b0000, 4'd1, 1'b0);
    do_one(0, 4'd8,  4'b0000, 4'd3, 1'b0);
    do_one(0, 4'd12, 4'b0000, 4'd6, 1'b0);
    do_one(0, 4'd0,  4'b0000, 4'd6, 1'b1);

    // Channel 1 full-scale: sum 60 must not overflow
    do_one(1, 4'd15, 4'b0000, 4'd3,  1'b0);
    do_one(1, 4'd15, 4'b0000, 4'd7,  1'b0);
    do_one(1, 4'd15, 4'b0000, 4'd11, 1'b0);
    do_one(1, 4'd15, 4'b0000, 4'd15, 1'b1);

    // Channel 2: fill with 15, then clear together with the accept of 8
    do_one(2, 4'd15, 4'b0000, 4'd3,  1'b0);
    do_one(2, 4'd15, 4'b0000, 4'd7,  1'b0);
    do_one(2, 4'd15, 4'b0000, 4'd11, 1'b0);
    do_one(2, 4'd15, 4'b0000, 4'd15, 1'b1);
    do_one(2, 4'd8,  4'b0100, 4'd2,  1'b0);
    do_one(2, 4'd8,  4'b0000, 4'd4,  1'b0);

    // Serve channel 3 once so the pointer wraps to 0
    do_one(3, 4'd0, 4'b0000, 4'd0, 1'b0);

    // All channels valid: order 0,1,2,3,0,1 and one grant every 3 clocks
    bus.req_data  = '0;
    bus.req_valid = 4'b1111;
    ng   = 0;
    last = 0;
    for (int cyc = 0; cyc < 40 && ng < 6; cyc++) begin
      @(negedge clk);
      if (bus.req_ready != 4'd0) begin
        idx = 0;
        for (int b = 0; b < 4; b++) if (bus.req_ready[b]) idx = b;
        check("rr_onehot", 32'($onehot(bus.req_ready)), 32'd1);
        check("rr_order", 32'(idx), 32'(exp_order[ng]));
        if (ng > 0) check("rr_spacing", 32'(cyc - last), 32'd3);
        last = cyc;
        ng++;
      end
      @(posedge clk); #1;
    end
    bus.req_valid = '0;
    check("rr_count", 32'(ng), 32'd6);
    @(posedge clk); @(posedge clk); #1;

    // Back-pressure: ch2 served, ch0/ch3 waiting, out_ready low
    bus.out_ready       = 1'b0;
    bus.req_data        = {4'd12, 4'd4, 4'd0, 4'd0};
    bus.req_valid       = 4'b1101;
    @(negedge clk);
    check("bp_grant", 32'(bus.req_ready), 32'b0100);
    @(posedge clk); #1;
    bus.req_valid[2] = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("bp_valid", 32'(bus.out_valid), 32'd1);
    check("bp_mean", 32'(bus.out_mean), 32'd5);
    check("bp_ch", 32'(bus.out_ch), 32'd2);
    check("bp_warm", 32'(bus.out_warm), 32'd1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("hold_valid", 32'(bus.out_valid), 32'd1);
      check("hold_mean", 32'(bus.out_mean), 32'd5);
      check("hold_ch", 32'(bus.out_ch), 32'd2);
      check("hold_ready", 32'(bus.req_ready), 32'd0);
    end
    @(posedge clk); #1;
    bus.out_ready = 1'b1;
    @(negedge clk);
    check("release_valid", 32'(bus.out_valid), 32'd1);
    @(negedge clk);
    check("next_grant", 32'(bus.req_ready), 32'b1000);
    @(posedge clk); #1;
    bus.req_valid[3] = 1'b0;
    bus.out_ready    = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("ch3_valid", 32'(bus.out_valid), 32'd1);
    check("ch3_mean", 32'(bus.out_mean), 32'd3);
    check("ch3_ch", 32'(bus.out_ch), 32'd3);

    // Asynchronous reset while holding a result in OUT
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_valid", 32'(bus.out_valid), 32'd0);
    check("arst_mean", 32'(bus.out_mean), 32'd0);
    check("arst_ch", 32'(bus.out_ch), 32'd0);
    check("arst_ready", 32'(bus.req_ready), 32'd0);
    @(posedge clk); #1;
    bus.req_data      = {4'd4, 4'd0, 4'd0, 4'd8};
    bus.req_valid     = 4'b1001;
    bus.out_ready     = 1'b1;
    rst_n             = 1'b1;
    do_one(0, 4'd8, 4'b0000, 4'd2, 1'b0);
    do_one(3, 4'd4, 4'b0000, 4'd1, 1'b0);
    bus.req_valid = '0;
    @(posedge clk); #1;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
